// File: rtl/conversor_formato_pf_if.sv
// Streaming port bundle for the fixed-point format converter: input and output
// valid/ready channels plus saturation status and clear.
interface conversor_formato_pf_if #(
  parameter int IW_IN  = 11,
  parameter int FW_IN  = 14,
  parameter int IW_OUT = 31,
  parameter int FW_OUT = 19,
  parameter int CNT_W  = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [IW_IN+FW_IN-1:0]    in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [IW_OUT+FW_OUT-1:0]  out_data;
  logic                      out_sat;
  logic                      sat_sticky;
  logic                      clr_sat;
  logic [CNT_W-1:0]          sat_count;

  modport slave (
    input  in_valid, in_data, out_ready, clr_sat,
    output in_ready, out_valid, out_data, out_sat, sat_sticky, sat_count
  );

  modport master (
    output in_valid, in_data, out_ready, clr_sat,
    input  in_ready, out_valid, out_data, out_sat, sat_sticky, sat_count
  );
endinterface

// File: rtl/conversor_formato_pf.sv
// Two-stage signed fixed-point converter Q(IW_IN.FW_IN) -> Q(IW_OUT.FW_OUT) with saturation.
// Define CONV_ROUND_EN for round-half-up when fraction bits are dropped; otherwise truncate.
module conversor_formato_pf #(
  parameter int IW_IN  = 11,
  parameter int FW_IN  = 14,
  parameter int IW_OUT = 31,
  parameter int FW_OUT = 19,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  reset,
  conversor_formato_pf_if.slave bus
);
  localparam int W_IN  = IW_IN + FW_IN;
  localparam int W1    = IW_IN + 1 + FW_OUT;
  localparam int W_OUT = IW_OUT + FW_OUT;

  logic             s1_valid, s2_valid;
  logic             s1_load, s2_load;
  logic [W1-1:0]    s1_data, s1_next;
  logic [W_OUT-1:0] s2_data, s2_next;
  logic             s2_sat, sat_next;
  logic             sat_xfer;

  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  // S1: align the fraction field; one spare integer bit absorbs the rounding carry
  if (FW_OUT >= FW_IN) begin : g_frac_pad
    localparam int PAD = FW_OUT - FW_IN;
    assign s1_next = W1'($signed(bus.in_data)) << PAD;
  end else begin : g_frac_drop
    localparam int D = FW_IN - FW_OUT;
    logic [W_IN:0] ext;
    assign ext = {bus.in_data[W_IN-1], bus.in_data};
`ifdef CONV_ROUND_EN
    logic [W_IN:0] sum;
    logic          unused_rnd_lsb;
    assign sum            = ext + ((W_IN+1)'(1) << (D-1));
    assign s1_next        = sum[W_IN:D];
    assign unused_rnd_lsb = ^sum[D-1:0];
`else
    logic unused_trunc_lsb;
    assign s1_next          = ext[W_IN:D];
    assign unused_trunc_lsb = ^ext[D-1:0];
`endif
  end

  // S2: fit the integer field, clamping when the upper bits are not pure sign
  if (IW_OUT >= IW_IN + 1) begin : g_int_ext
    assign s2_next  = W_OUT'($signed(s1_data));
    assign sat_next = 1'b0;
  end else begin : g_int_sat
    localparam logic [W_OUT-1:0] MAX_POS = {1'b0, {(W_OUT-1){1'b1}}};
    logic [W1-W_OUT:0] top;
    logic              fits;
    assign top      = s1_data[W1-1:W_OUT-1];
    assign fits     = (top == '0) || (top == '1);
    assign sat_next = !fits;
    assign s2_next  = fits ? s1_data[W_OUT-1:0] : (s1_data[W1-1] ? ~MAX_POS : MAX_POS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sat   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) s1_data <= s1_next;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s2_next;
          s2_sat  <= sat_next;
        end
      end
    end
  end

  assign sat_xfer = s2_valid && bus.out_ready && s2_sat;

  // A clear coinciding with a clamped transfer still records that transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sat_sticky <= 1'b0;
      bus.sat_count  <= '0;
    end else if (bus.clr_sat) begin
      bus.sat_sticky <= sat_xfer;
      bus.sat_count  <= sat_xfer ? CNT_W'(1) : '0;
    end else if (sat_xfer) begin
      bus.sat_sticky <= 1'b1;
      if (bus.sat_count != '1) bus.sat_count <= bus.sat_count + CNT_W'(1);
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_sat   = s2_sat;
endmodule

// File: tb/tb_conversor_formato_pf.sv
// Directed bench for conversor_formato_pf: default widening instance plus a
// Q8.8 -> Q4.4 narrowing instance exercising rounding, saturation and backpressure.
module tb_conversor_formato_pf;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

`ifdef CONV_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  conversor_formato_pf_if bd ();
  conversor_formato_pf_if #(.IW_IN(8), .FW_IN(8), .IW_OUT(4), .FW_OUT(4), .CNT_W(3)) bs ();

  conversor_formato_pf u_def (.clk(clk), .reset(reset), .bus(bd.slave));
  conversor_formato_pf #(.IW_IN(8), .FW_IN(8), .IW_OUT(4), .FW_OUT(4), .CNT_W(3))
    u_small (.clk(clk), .reset(reset), .bus(bs.slave));

  typedef struct { logic [24:0] din; logic [49:0] dout; } vec_d_t;
  typedef struct { logic [15:0] din; logic [7:0] dout; logic sat; } vec_s_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Integer reference for Q8.8 -> Q4.4: shift in 1/16 units, then clamp
  function automatic logic [8:0] model(input logic [15:0] din);
    int v;
    int q;
    v = int'($signed(din));
    if (RND) v = v + 8;
    q = v >>> 4;
    if (q > 127)  return {1'b1, 8'h7F};
    if (q < -128) return {1'b1, 8'h80};
    return {1'b0, q[7:0]};
  endfunction

  task automatic apply_small(input logic [15:0] din, input logic [7:0] dout,
                             input logic sat, input string nm);
    bs.in_valid  = 1'b1;
    bs.in_data   = din;
    bs.out_ready = 1'b1;
    #1;
    chk({nm, "_rdy"}, bs.in_ready, 1);
    tick();
    bs.in_valid = 1'b0;
    #1;
    chk({nm, "_lat1"}, bs.out_valid, 0);
    tick();
    chk({nm, "_vld"}, bs.out_valid, 1);
    chk({nm, "_data"}, bs.out_data, dout);
    chk({nm, "_sat"}, bs.out_sat, sat);
  endtask

  task automatic apply_def(input logic [24:0] din, input logic [49:0] dout, input string nm);
    bd.in_valid  = 1'b1;
    bd.in_data   = din;
    bd.out_ready = 1'b1;
    tick();
    bd.in_valid = 1'b0;
    #1;
    chk({nm, "_lat1"}, bd.out_valid, 0);
    tick();
    chk({nm, "_vld"}, bd.out_valid, 1);
    chk({nm, "_data"}, bd.out_data, dout);
    chk({nm, "_sat"}, bd.out_sat, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_d_t tabd[6];
    vec_s_t tab2[3];
    vec_s_t tab3[8];
    logic [15:0] t4[8];
    logic [8:0]  q[$];
    logic [8:0]  exp9;
    logic        held_v;
    logic [7:0]  held_d;
    logic        in_fire, out_fire;
    int sent, got, occ, cyc;

    tabd[0] = '{25'h1FFC000, 50'h3FFFFFFF80000};
    tabd[1] = '{25'h0004001, 50'h0000000080020};
    tabd[2] = '{25'h0FFFFFF, 50'h000001FFFFFE0};
    tabd[3] = '{25'h1000000, 50'h3FFFFE0000000};
    tabd[4] = '{25'h0000001, 50'h0000000000020};
    tabd[5] = '{25'h1FFFFFF, 50'h3FFFFFFFFFFE0};

    tab2[0] = '{16'h0180, 8'h18, 1'b0};
    tab2[1] = '{16'h7F00, 8'h7F, 1'b1};
    tab2[2] = '{16'h8000, 8'h80, 1'b1};

    tab3[0] = '{16'h0108, RND ? 8'h11 : 8'h10, 1'b0};
    tab3[1] = '{16'hFEF8, RND ? 8'hF0 : 8'hEF, 1'b0};
    tab3[2] = '{16'h0000, 8'h00, 1'b0};
    tab3[3] = '{16'h07F0, 8'h7F, 1'b0};
    tab3[4] = '{16'h07F8, 8'h7F, RND};
    tab3[5] = '{16'hF800, 8'h80, 1'b0};
    tab3[6] = '{16'hF7F0, 8'h80, 1'b1};
    tab3[7] = '{16'hFFFF, RND ? 8'h00 : 8'hFF, 1'b0};

    t4 = '{16'h0180, 16'h7F00, 16'h0108, 16'hFEF8, 16'h8000, 16'h0010, 16'hFFF0, 16'h0400};

    reset = 1'b1;
    bd.in_valid = 1'b0; bd.in_data = '0; bd.out_ready = 1'b0; bd.clr_sat = 1'b0;
    bs.in_valid = 1'b0; bs.in_data = '0; bs.out_ready = 1'b0; bs.clr_sat = 1'b0;
    tick();
    tick();
    chk("rst_def_vld", bd.out_valid, 0);
    chk("rst_def_data", bd.out_data, 0);
    chk("rst_small_vld", bs.out_valid, 0);
    chk("rst_small_cnt", bs.sat_count, 0);
    chk("rst_small_sticky", bs.sat_sticky, 0);
    reset = 1'b0;
    #1;
    chk("rst_def_rdy", bd.in_ready, 1);
    chk("rst_small_rdy", bs.in_ready, 1);

    // T1: default widening
    for (int i = 0; i < 6; i++) apply_def(tabd[i].din, tabd[i].dout, $sformatf("t1_%0d", i));
    tick();
    chk("t1_cnt", bd.sat_count, 0);
    chk("t1_sticky", bd.sat_sticky, 0);

    // T2: narrowing with saturation
    for (int i = 0; i < 3; i++)
      apply_small(tab2[i].din, tab2[i].dout, tab2[i].sat, $sformatf("t2_%0d", i));
    tick();
    chk("t2_cnt", bs.sat_count, 2);
    chk("t2_sticky", bs.sat_sticky, 1);

    // T3: rounding / truncation boundaries
    for (int i = 0; i < 8; i++)
      apply_small(tab3[i].din, tab3[i].dout, tab3[i].sat, $sformatf("t3_%0d", i));
    tick();
    chk("t3_cnt", bs.sat_count, RND ? 4 : 3);

    // T4: random backpressure against occupancy and value model
    tick();
    sent = 0; got = 0; occ = 0; cyc = 0; held_v = 1'b0; held_d = '0;
    while (got < 8 && cyc < 200) begin
      bs.out_ready = 1'($urandom_range(0, 1));
      bs.in_valid  = (sent < 8);
      bs.in_data   = (sent < 8) ? t4[sent] : 16'h0000;
      #1;
      if (held_v) chk("t4_hold", {bs.out_valid, bs.out_data}, {1'b1, held_d});
      chk("t4_in_ready", bs.in_ready, !(occ == 2 && !bs.out_ready));
      in_fire  = bs.in_valid && bs.in_ready;
      out_fire = bs.out_valid && bs.out_ready;
      if (out_fire) begin
        exp9 = (q.size() != 0) ? q.pop_front() : 9'h1FF;
        chk($sformatf("t4_out_%0d", got), {bs.out_sat, bs.out_data}, exp9);
        got++;
      end
      held_v = bs.out_valid && !bs.out_ready;
      held_d = bs.out_data;
      if (in_fire) begin
        q.push_back(model(bs.in_data));
        sent++;
      end
      occ = occ + int'(in_fire) - int'(out_fire);
      tick();
      cyc++;
    end
    bs.in_valid = 1'b0;
    chk("t4_got", got, 8);
    chk("t4_left", q.size(), 0);

    // T5: clear vs clamped transfer, counter ceiling
    bs.out_ready = 1'b0;
    tick();
    chk("t5_pre", bs.sat_count, RND ? 6 : 5);
    bs.in_valid = 1'b1;
    bs.in_data  = 16'h7F00;
    tick();
    bs.in_valid = 1'b0;
    tick();
    chk("t5_held", bs.out_valid, 1);
    bs.clr_sat   = 1'b1;
    bs.out_ready = 1'b1;
    tick();
    bs.clr_sat = 1'b0;
    chk("t5_clr_cnt", bs.sat_count, 1);
    chk("t5_clr_sticky", bs.sat_sticky, 1);
    bs.clr_sat = 1'b1;
    tick();
    bs.clr_sat = 1'b0;
    chk("t5_zero_cnt", bs.sat_count, 0);
    chk("t5_zero_sticky", bs.sat_sticky, 0);
    bs.in_valid = 1'b1;
    bs.in_data  = 16'h8000;
    repeat (7) tick();
    bs.in_valid = 1'b0;
    repeat (3) tick();
    chk("t5_full", bs.sat_count, 7);
    apply_small(16'h7F00, 8'h7F, 1'b1, "t5_extra");
    tick();
    chk("t5_ceiling", bs.sat_count, 7);
    chk("t5_sticky", bs.sat_sticky, 1);

    // T6: asynchronous reset with both stages full
    bs.out_ready = 1'b0;
    bs.in_valid  = 1'b1;
    bs.in_data   = 16'h0180;
    tick();
    bs.in_data = 16'h0200;
    tick();
    bs.in_valid = 1'b0;
    #1;
    chk("t6_full", bs.in_ready, 0);
    chk("t6_vld_pre", bs.out_valid, 1);
    reset = 1'b1;
    #1;
    chk("t6_async_vld", bs.out_valid, 0);
    chk("t6_async_data", bs.out_data, 0);
    chk("t6_async_sticky", bs.sat_sticky, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_rdy", bs.in_ready, 1);
    bs.out_ready = 1'b1;
    tick();
    chk("t6_nostale", bs.out_valid, 0);
    apply_small(16'hFF00, 8'hF0, 1'b0, "t6_next");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
